// File: rtl/keynsham_timer_sched.sv
// keynsham_timer_sched
// ---------------------
// Multiplexes a single keynsham_timer into NUM_CHANNELS one-shot alarm
// channels. The scheduler is the timer's only bus master: it loads the
// timer with the nearest pending deadline, services the timer interrupt,
// charges the elapsed time to every armed channel and pulses fire[i] when
// channel i expires.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   arm           one-cycle arm strobe per channel
//   arm_delay     32-bit delay per channel, channel i at [32i+31:32i]
//   busy          channel armed or arm waiting to be merged
//   fire          one-cycle expiry pulse per channel (registered)
//   tmr_access    timer bus_access / timer_cs
//   tmr_reg_sel   0 count, 1 reload, 2 control, 3 eoi
//   tmr_wr_en     timer write strobe
//   tmr_wr_val    timer write data
//   tmr_bytesel   always 4'hf
//   tmr_ack       timer bus_ack, one cycle after the access cycle
//   tmr_data      timer read data, combinational on reg_sel
//   tmr_irq       timer interrupt
//   dbg_state     current scheduler state, for observation only
//
// Timer bus handshake: a transaction is one cycle with tmr_access=1 (the
// issue cycle) followed by waiting with tmr_access=0 until tmr_ack. The
// reg_sel, wr_en and wr_val fields are held from the issue cycle until the
// ack cycle; read data is captured in the ack cycle. tmr_access is raised
// on the transition into a bus state, so each transaction takes exactly two
// cycles and tmr_access is never high in two consecutive cycles.
module keynsham_timer_sched #(
  parameter int NUM_CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CHANNELS-1:0]   arm,
  input  logic [32*NUM_CHANNELS-1:0] arm_delay,
  output logic [NUM_CHANNELS-1:0]   busy,
  output logic [NUM_CHANNELS-1:0]   fire,
  output logic                      tmr_access,
  output logic [1:0]                tmr_reg_sel,
  output logic                      tmr_wr_en,
  output logic [31:0]               tmr_wr_val,
  output logic [3:0]                tmr_bytesel,
  input  logic                      tmr_ack,
  input  logic [31:0]               tmr_data,
  input  logic                      tmr_irq,
  output logic [3:0]                dbg_state
);

  localparam logic [1:0]  SEL_COUNT  = 2'd0;
  localparam logic [1:0]  SEL_RELOAD = 2'd1;
  localparam logic [1:0]  SEL_CTRL   = 2'd2;
  localparam logic [1:0]  SEL_EOI    = 2'd3;
  // irq_enable=1, enabled=1, periodic=0 (one-shot)
  localparam logic [31:0] CTRL_START = 32'h0000_0006;
  localparam logic [31:0] CTRL_STOP  = 32'h0000_0000;
  localparam logic [31:0] EOI_VAL    = 32'h0000_0001;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_UPDATE = 4'd1,
    S_SELECT = 4'd2,
    S_LOAD   = 4'd3,
    S_START  = 4'd4,
    S_RUN    = 4'd5,
    S_STOP   = 4'd6,
    S_READ   = 4'd7,
    S_EOI    = 4'd8
  } state_t;

  state_t state;

  logic [NUM_CHANNELS-1:0] armed;
  logic [NUM_CHANNELS-1:0] pending;
  logic [31:0]             remaining  [NUM_CHANNELS];
  logic [31:0]             pend_delay [NUM_CHANNELS];
  logic [31:0]             prog;     // delay last loaded into the timer
  logic [31:0]             elapsed;  // cycles charged at the next UPDATE

  // Result of the UPDATE step, computed from the current registers.
  logic [NUM_CHANNELS-1:0] upd_armed;
  logic [NUM_CHANNELS-1:0] upd_fire;
  logic [31:0]             upd_rem [NUM_CHANNELS];

  // Nearest deadline among armed channels.
  logic [31:0]             min_rem;
  logic                    min_found;

  assign busy        = armed | pending;
  assign tmr_bytesel = 4'hf;
  assign dbg_state   = state;

  // Charge elapsed time, retire expired channels, then merge pending arms.
  // A pending arm is applied after expiry so that a channel expiring and
  // re-armed in the same UPDATE fires once and stays armed with the new
  // delay.
  always_comb begin
    upd_armed = armed;
    upd_fire  = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      upd_rem[i] = remaining[i];
      if (armed[i]) begin
        upd_rem[i] = (remaining[i] > elapsed) ? (remaining[i] - elapsed) : 32'd0;
        if (upd_rem[i] == 32'd0) begin
          upd_fire[i]  = 1'b1;
          upd_armed[i] = 1'b0;
        end
      end
      if (pending[i]) begin
        if (pend_delay[i] == 32'd0) begin
          upd_fire[i]  = 1'b1;
          upd_armed[i] = 1'b0;
        end else begin
          upd_armed[i] = 1'b1;
          upd_rem[i]   = pend_delay[i];
        end
      end
    end
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    min_rem   = 32'hffff_ffff;
    min_found = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (armed[i] && (!min_found || remaining[i] < min_rem)) begin
        min_rem   = remaining[i];
        min_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      armed       <= '0;
      pending     <= '0;
      prog        <= 32'd0;
      elapsed     <= 32'd0;
      fire        <= '0;
      tmr_access  <= 1'b0;
      tmr_reg_sel <= SEL_COUNT;
      tmr_wr_en   <= 1'b0;
      tmr_wr_val  <= 32'd0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        remaining[i]  <= 32'd0;
        pend_delay[i] <= 32'd0;
      end
    end else begin
      fire       <= '0;
      // The issue cycle is always exactly one cycle long.
      tmr_access <= 1'b0;

      // Arm capture runs in every state; last strobe before merge wins.
      // An arm arriving during UPDATE stays pending for the next pass.
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (arm[i]) begin
          pending[i]    <= 1'b1;
          pend_delay[i] <= arm_delay[32*i +: 32];
        end else if (state == S_UPDATE) begin
          pending[i] <= 1'b0;
        end
      end

      case (state)
        S_IDLE: begin
          // Timer is stopped here, so nothing has elapsed.
          if (|pending) begin
            elapsed <= 32'd0;
            state   <= S_UPDATE;
          end
        end

        S_UPDATE: begin
          armed <= upd_armed;
          fire  <= upd_fire;
          for (int i = 0; i < NUM_CHANNELS; i++) begin
            remaining[i] <= upd_rem[i];
          end
          state <= (|upd_armed) ? S_SELECT : S_IDLE;
        end

        S_SELECT: begin
          prog        <= min_rem;
          tmr_access  <= 1'b1;
          tmr_reg_sel <= SEL_RELOAD;
          tmr_wr_en   <= 1'b1;
          tmr_wr_val  <= min_rem;
          state       <= S_LOAD;
        end

        S_LOAD: begin
          if (tmr_ack) begin
            tmr_access  <= 1'b1;
            tmr_reg_sel <= SEL_CTRL;
            tmr_wr_en   <= 1'b1;
            tmr_wr_val  <= CTRL_START;
            state       <= S_START;
          end
        end

        S_START: begin
          if (tmr_ack) begin
            tmr_reg_sel <= SEL_COUNT;
            tmr_wr_en   <= 1'b0;
            tmr_wr_val  <= 32'd0;
            state       <= S_RUN;
          end
        end

        S_RUN: begin
          // New arms preempt the running deadline so they are merged
          // promptly; the stop/read pass charges the partial run.
          if (tmr_irq || (|pending)) begin
            tmr_access  <= 1'b1;
            tmr_reg_sel <= SEL_CTRL;
            tmr_wr_en   <= 1'b1;
            tmr_wr_val  <= CTRL_STOP;
            state       <= S_STOP;
          end
        end

        S_STOP: begin
          if (tmr_ack) begin
            tmr_access  <= 1'b1;
            tmr_reg_sel <= SEL_COUNT;
            tmr_wr_en   <= 1'b0;
            tmr_wr_val  <= 32'd0;
            state       <= S_READ;
          end
        end

        S_READ: begin
          if (tmr_ack) begin
            // The timer counts down from prog and is stopped now, so the
            // count read back never exceeds prog.
            elapsed     <= prog - tmr_data;
            tmr_access  <= 1'b1;
            tmr_reg_sel <= SEL_EOI;
            tmr_wr_en   <= 1'b1;
            tmr_wr_val  <= EOI_VAL;
            state       <= S_EOI;
          end
        end

        S_EOI: begin
          // Written on every pass: clears an irq that raced the stop.
          if (tmr_ack) begin
            tmr_reg_sel <= SEL_COUNT;
            tmr_wr_en   <= 1'b0;
            tmr_wr_val  <= 32'd0;
            state       <= S_UPDATE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keynsham_timer_sched.sv
module tb_keynsham_timer_sched;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      arm;
  logic [32*N-1:0]   arm_delay;
  logic [N-1:0]      busy;
  logic [N-1:0]      fire;
  logic              tmr_access;
  logic [1:0]        tmr_reg_sel;
  logic              tmr_wr_en;
  logic [31:0]       tmr_wr_val;
  logic [3:0]        tmr_bytesel;
  logic              tmr_ack;
  logic [31:0]       tmr_data;
  logic              tmr_irq;
  logic [3:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  keynsham_timer_sched #(.NUM_CHANNELS(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .arm_delay   (arm_delay),
    .busy        (busy),
    .fire        (fire),
    .tmr_access  (tmr_access),
    .tmr_reg_sel (tmr_reg_sel),
    .tmr_wr_en   (tmr_wr_en),
    .tmr_wr_val  (tmr_wr_val),
    .tmr_bytesel (tmr_bytesel),
    .tmr_ack     (tmr_ack),
    .tmr_data    (tmr_data),
    .tmr_irq     (tmr_irq),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- timer slave model ----------------
  // Down-counter loaded from reload when enabled; in one-shot mode it
  // raises irq and stops when the count reaches zero.
  logic [31:0] t_count, t_reload;
  logic        t_en, t_irqen, t_irq, t_ack;

  always @(posedge clk) begin
    if (rst) begin
      t_count <= 0; t_reload <= 0; t_en <= 0; t_irqen <= 0; t_irq <= 0; t_ack <= 0;
    end else begin
      t_ack <= tmr_access;
      if (t_en) begin
        if (t_count == 32'd1) begin
          t_count <= 0;
          t_en    <= 0;
          if (t_irqen) t_irq <= 1;
        end else begin
          t_count <= t_count - 1;
        end
      end
      if (tmr_access && tmr_wr_en) begin
        case (tmr_reg_sel)
          2'd0: t_count <= tmr_wr_val;
          2'd1: t_reload <= tmr_wr_val;
          2'd2: begin
            t_irqen <= tmr_wr_val[2];
            t_en    <= tmr_wr_val[1];
            if (tmr_wr_val[1]) t_count <= t_reload;
          end
          default: t_irq <= 0;
        endcase
      end
    end
  end

  assign tmr_ack  = t_ack;
  assign tmr_irq  = t_irq;
  assign tmr_data = (tmr_reg_sel == 2'd0) ? t_count :
                    (tmr_reg_sel == 2'd1) ? t_reload :
                    (tmr_reg_sel == 2'd2) ? {29'd0, t_irqen, t_en, 1'b0} : 32'd0;

  // ---------------- monitors ----------------
  typedef struct packed {
    logic [1:0]  sel;
    logic        we;
    logic [31:0] val;
  } bus_t;

  int          fire_q [N][$];
  bus_t        bus_log[$];
  logic [31:0] rd_log[$];
  int          acc_viol = 0;
  logic        prev_acc = 1'b0;

  always @(negedge clk) begin
    for (int c = 0; c < N; c++) if (fire[c]) fire_q[c].push_back(cyc);
    if (tmr_access) begin
      bus_log.push_back({tmr_reg_sel, tmr_wr_en, tmr_wr_val});
      if (prev_acc) acc_viol <= acc_viol + 1;
    end
    if (t_ack && !tmr_wr_en && tmr_reg_sel == 2'd0) rd_log.push_back(tmr_data);
    prev_acc <= tmr_access;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_arm(input int ch, input logic [31:0] d);
    arm[ch] = 1'b1;
    arm_delay[32*ch +: 32] = d;
  endtask

  task automatic clear_logs();
    for (int c = 0; c < N; c++) fire_q[c].delete();
    bus_log.delete();
    rd_log.delete();
  endtask

  task automatic wait_fire(input int ch, input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (fire_q[ch].size() > 0) begin
        ok = 1;
        break;
      end
    end
  endtask

  function automatic logic [31:0] reload_n(input int n);
    int k = 0;
    foreach (bus_log[i]) begin
      if (bus_log[i].sel == 2'd1 && bus_log[i].we) begin
        if (k == n) return bus_log[i].val;
        k++;
      end
    end
    return 32'hffff_ffff;
  endfunction

  function automatic int n_reloads();
    int k = 0;
    foreach (bus_log[i]) if (bus_log[i].sel == 2'd1 && bus_log[i].we) k++;
    return k;
  endfunction

  function automatic int total_fires();
    int k = 0;
    for (int c = 0; c < N; c++) k += fire_q[c].size();
    return k;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; arm = '0; arm_delay = '0;
    repeat (3) step();
    checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
    checks++; if (fire !== '0) begin errors++; $display("FAIL reset_fire got %h want 0", fire); end
    checks++; if (tmr_access !== 1'b0) begin errors++; $display("FAIL reset_access got %b want 0", tmr_access); end
    checks++; if (tmr_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", tmr_wr_en); end
    checks++; if (tmr_reg_sel !== 2'd0) begin errors++; $display("FAIL reset_reg_sel got %0d want 0", tmr_reg_sel); end
    checks++; if (tmr_wr_val !== 32'd0) begin errors++; $display("FAIL reset_wr_val got %h want 0", tmr_wr_val); end
    checks++; if (tmr_bytesel !== 4'hf) begin errors++; $display("FAIL bytesel got %h want f", tmr_bytesel); end
    rst = 0;
    step();
  endtask

  task automatic test_single();
    int a, lat;
    bit ok;
    logic [2:0] exp_sw [5] = '{3'b011, 3'b101, 3'b101, 3'b000, 3'b111};
    logic [31:0] exp_v [3] = '{32'd100, 32'd6, 32'd0};
    clear_logs();
    a = cyc + 1;
    set_arm(0, 100); step(); arm = '0;
    wait_fire(0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got no fire want fire"); end
    checks++; if (ok && busy[0] !== 1'b0) begin errors++; $display("FAIL single_busy_at_fire got %b want 0", busy[0]); end
    repeat (10) step();
    lat = ok ? fire_q[0][0] - a : -1;
    checks++; if (lat < 100 || lat > 124) begin errors++; $display("FAIL single_latency got %0d want 100..124", lat); end
    checks++; if (fire_q[0].size() != 1) begin errors++; $display("FAIL single_pulses got %0d want 1", fire_q[0].size()); end
    checks++; if (bus_log.size() != 5) begin errors++; $display("FAIL single_bus_len got %0d want 5", bus_log.size()); end
    for (int i = 0; i < 5 && i < bus_log.size(); i++) begin
      checks++;
      if ({bus_log[i].sel, bus_log[i].we} !== exp_sw[i] ||
          (i < 3 && bus_log[i].val !== exp_v[i])) begin
        errors++;
        $display("FAIL single_bus_%0d got sel=%0d we=%b val=%0d want sel/we=%b", i,
                 bus_log[i].sel, bus_log[i].we, bus_log[i].val, exp_sw[i]);
      end
    end
    checks++; if (t_en !== 1'b0 || t_irq !== 1'b0) begin errors++; $display("FAIL single_timer_left got en=%b irq=%b want 0 0", t_en, t_irq); end
  endtask

  task automatic test_two_same_cycle();
    int a, l0, l1;
    bit ok;
    clear_logs();
    a = cyc + 1;
    set_arm(0, 300); set_arm(1, 50); step(); arm = '0;
    wait_fire(0, 500, ok);
    repeat (5) step();
    checks++; if (reload_n(0) !== 32'd50) begin errors++; $display("FAIL two_reload0 got %0d want 50", reload_n(0)); end
    checks++; if (reload_n(1) !== 32'd250) begin errors++; $display("FAIL two_reload1 got %0d want 250", reload_n(1)); end
    checks++;
    if (fire_q[0].size() != 1 || fire_q[1].size() != 1) begin
      errors++; $display("FAIL two_pulses got %0d,%0d want 1,1", fire_q[0].size(), fire_q[1].size());
    end else begin
      l0 = fire_q[0][0] - a; l1 = fire_q[1][0] - a;
      checks++; if (l1 < 50 || l1 > 74) begin errors++; $display("FAIL two_lat1 got %0d want 50..74", l1); end
      checks++; if (l0 < 300 || l0 > 348) begin errors++; $display("FAIL two_lat0 got %0d want 300..348", l0); end
    end
  endtask

  task automatic test_preempt();
    int a, b, l2, l3;
    bit ok;
    clear_logs();
    a = cyc + 1;
    set_arm(2, 1000); step(); arm = '0;
    while (cyc + 1 < a + 200) step();
    b = cyc + 1;
    set_arm(3, 10); step(); arm = '0;
    wait_fire(2, 1200, ok);
    repeat (5) step();
    checks++;
    if (rd_log.size() < 1 || rd_log[0] < 780 || rd_log[0] > 810) begin
      errors++; $display("FAIL preempt_read got %0d (n=%0d) want 780..810", (rd_log.size() > 0) ? rd_log[0] : 0, rd_log.size());
    end
    checks++; if (reload_n(0) !== 32'd1000) begin errors++; $display("FAIL preempt_reload0 got %0d want 1000", reload_n(0)); end
    checks++; if (reload_n(1) !== 32'd10) begin errors++; $display("FAIL preempt_reload1 got %0d want 10", reload_n(1)); end
    checks++;
    if (fire_q[2].size() != 1 || fire_q[3].size() != 1) begin
      errors++; $display("FAIL preempt_pulses got %0d,%0d want 1,1", fire_q[2].size(), fire_q[3].size());
    end else begin
      l2 = fire_q[2][0] - a; l3 = fire_q[3][0] - b;
      checks++; if (l3 < 10 || l3 > 50) begin errors++; $display("FAIL preempt_lat3 got %0d want 10..50", l3); end
      checks++; if (l2 < 1000 || l2 > 1048) begin errors++; $display("FAIL preempt_lat2 got %0d want 1000..1048", l2); end
    end
  endtask

  task automatic test_zero_delay();
    int a, lat;
    bit ok;
    clear_logs();
    a = cyc + 1;
    set_arm(1, 0); step(); arm = '0;
    wait_fire(1, 10, ok);
    repeat (5) step();
    lat = ok ? fire_q[1][0] - a : -1;
    checks++; if (lat < 0 || lat > 4) begin errors++; $display("FAIL zero_latency got %0d want 0..4", lat); end
    checks++; if (n_reloads() != 0) begin errors++; $display("FAIL zero_reload_writes got %0d want 0", n_reloads()); end
    checks++; if (busy !== '0) begin errors++; $display("FAIL zero_busy got %h want 0", busy); end
  endtask

  task automatic test_rearm();
    int a, lat;
    bit ok;
    clear_logs();
    a = cyc + 1;
    set_arm(0, 50); step(); arm = '0;
    while (cyc + 1 < a + 20) step();
    set_arm(0, 500); step(); arm = '0;
    wait_fire(0, 700, ok);
    repeat (20) step();
    checks++; if (fire_q[0].size() != 1) begin errors++; $display("FAIL rearm_pulses got %0d want 1", fire_q[0].size()); end
    lat = ok ? fire_q[0][0] - a : -1;
    checks++; if (lat < 520 || lat > 560) begin errors++; $display("FAIL rearm_latency got %0d want 520..560", lat); end
  endtask

  task automatic test_reset_in_run();
    set_arm(0, 400); set_arm(1, 600); step(); arm = '0;
    repeat (50) step();
    rst = 1; step();
    checks++; if (busy !== '0) begin errors++; $display("FAIL rstrun_busy got %h want 0", busy); end
    checks++; if (tmr_access !== 1'b0) begin errors++; $display("FAIL rstrun_access got %b want 0", tmr_access); end
    rst = 0;
    clear_logs();
    repeat (900) step();
    checks++; if (total_fires() != 0) begin errors++; $display("FAIL rstrun_fires got %0d want 0", total_fires()); end
    checks++; if (bus_log.size() != 0) begin errors++; $display("FAIL rstrun_bus got %0d want 0", bus_log.size()); end
  endtask

  // Idle scheduler: each fire must land in [arm+d, arm+d+24].
  task automatic test_random_single();
    for (int it = 0; it < 6; it++) begin
      int ch, d, a, lat, others;
      bit ok;
      ch = $urandom_range(0, N-1);
      d  = $urandom_range(1, 200);
      clear_logs();
      a = cyc + 1;
      set_arm(ch, d); step(); arm = '0;
      wait_fire(ch, d + 60, ok);
      repeat (5) step();
      lat = ok ? fire_q[ch][0] - a : -1;
      others = total_fires() - fire_q[ch].size();
      checks++;
      if (fire_q[ch].size() != 1 || others != 0 || lat < d || lat > d + 24) begin
        errors++;
        $display("FAIL rand_single ch=%0d d=%0d got lat=%0d pulses=%0d others=%0d want %0d..%0d once",
                 ch, d, lat, fire_q[ch].size(), others, d, d + 24);
      end
    end
  endtask

  // Overlapping channels: never early, lateness bounded by reschedules.
  task automatic test_random_multi();
    bit active [N];
    int arm_c [N], dly [N], ev [N];
    int k = 0, lat, hi;
    bit any;
    for (int c = 0; c < N; c++) active[c] = 0;
    do begin
      step();
      arm = '0;
      for (int c = 0; c < N; c++) begin
        if (fire[c]) begin
          checks++;
          if (!active[c]) begin
            errors++; $display("FAIL multi_spurious ch=%0d got fire want none", c);
          end else begin
            lat = cyc - arm_c[c];
            hi  = dly[c] + 24 + 16 * (ev[c] + 1);
            if (lat < dly[c] || lat > hi) begin
              errors++; $display("FAIL multi_window ch=%0d got lat=%0d want %0d..%0d", c, lat, dly[c], hi);
            end
            active[c] = 0;
            for (int o = 0; o < N; o++) if (active[o]) ev[o]++;
          end
        end
      end
      if (k < 2500 && $urandom_range(0, 19) == 0) begin
        int ch, d;
        ch = $urandom_range(0, N-1);
        if (!active[ch]) begin
          d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 400);
          for (int o = 0; o < N; o++) if (active[o]) ev[o]++;
          set_arm(ch, d);
          active[ch] = 1; arm_c[ch] = cyc + 1; dly[ch] = d; ev[ch] = 0;
        end
      end
      any = 0;
      for (int c = 0; c < N; c++) any |= active[c];
      k++;
    end while ((k < 2500 || any) && k < 6000);
    arm = '0;
    checks++;
    if (any) begin
      errors++; $display("FAIL multi_timeout got channels still waiting want all fired");
    end
  endtask

  task automatic test_bus_spacing();
    checks++; if (acc_viol != 0) begin errors++; $display("FAIL bus_back_to_back got %0d want 0", acc_viol); end
  endtask

  initial begin
    arm = '0; arm_delay = '0; rst = 1;
    test_reset();
    test_single();
    test_two_same_cycle();
    test_preempt();
    test_zero_delay();
    test_rearm();
    test_reset_in_run();
    test_random_single();
    test_random_multi();
    repeat (10) step();
    test_bus_spacing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
